// File: rtl/ysyx_23060203_br_pkg.sv
// ysyx_23060203_br_pkg
//   Shared types and constants for the IDU control-transfer resolver:
//   - op_e    : control-transfer op kinds (BR, JAL, JALR)
//   - state_e : resolver FSM states
//   - F3_*    : RV32 branch funct3 codes
//   - decode_op() maps the raw 2-bit decode op onto op_e (code 3 behaves as JAL)
package ysyx_23060203_br_pkg;

  typedef enum logic [1:0] {
    OP_BR   = 2'd0,
    OP_JAL  = 2'd1,
    OP_JALR = 2'd2
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OPER  = 2'd1,
    ST_EVAL  = 2'd2,
    ST_REDIR = 2'd3
  } state_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // The unused op encoding 3 is folded onto JAL so decode never has to filter it.
  function automatic op_e decode_op(input logic [1:0] raw);
    case (raw)
      2'd0:    return OP_BR;
      2'd2:    return OP_JALR;
      default: return OP_JAL;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_23060203_br_cmp.sv
// ysyx_23060203_br_cmp
//   Combinational branch-condition evaluator.
//   Ports:
//     a, b   in  XLEN  operands (rs1, rs2)
//     funct  in  3     RV32 branch funct3
//     taken  out 1     condition result (funct3 010/011 never taken)
//   All six relations come from a single XLEN+1-bit subtract a-b.
module ysyx_23060203_br_cmp
  import ysyx_23060203_br_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      funct,
  output logic            taken
);

  logic [XLEN:0] diff;
  logic          eq;
  logic          ltu;
  logic          lt;
  logic          ovf;

  // Zero-extended subtract: the extra top bit is the borrow, i.e. a < b unsigned.
  assign diff = {1'b0, a} - {1'b0, b};
  assign eq   = (diff[XLEN-1:0] == '0);
  assign ltu  = diff[XLEN];

  // Signed less-than is the result sign corrected by two's-complement overflow.
  assign ovf  = (a[XLEN-1] ^ b[XLEN-1]) & (diff[XLEN-1] ^ a[XLEN-1]);
  assign lt   = diff[XLEN-1] ^ ovf;

  always_comb begin
    taken = 1'b0;
    case (funct)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = ~eq;
      F3_BLT:  taken = lt;
      F3_BGE:  taken = ~lt;
      F3_BLTU: taken = ltu;
      F3_BGEU: taken = ~ltu;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ysyx_23060203_branch_ctl.sv
// ysyx_23060203_branch_ctl
//   Resolves one BR/JAL/JALR at a time in the IDU: latches the op from decode,
//   waits on the scoreboard for its source operands, evaluates condition and
//   target, and redirects the IFU through a valid/ready handshake when the
//   fetch path must change. Decode is stalled (in_ready=0) while busy.
//   Ports:
//     clock, reset_n            clock, asynchronous active-low reset
//     kill                      flush from a later stage, overrides everything
//     in_valid/in_ready         decode handshake
//     in_op/in_funct/in_pc/in_imm/in_rs1/in_rs2   op fields from decode
//     rs1_addr/rs2_addr         latched source indices to RF/scoreboard
//     rs1_busy/rs2_busy         scoreboard pending-write flags
//     rs1_data/rs2_data         operand data
//     redir_valid/redir_ready/redir_pc   redirect handshake to the IFU
//     done/done_taken           1-cycle retire pulse and resolved outcome
//   Build option:
//     YSYX_23060203_BTFN_EN  IFU predicts backward branches and JAL taken;
//                            redirect only on misprediction (JALR always).
module ysyx_23060203_branch_ctl
  import ysyx_23060203_br_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RAW  = 5
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            kill,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [2:0]      in_funct,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [RAW-1:0]  in_rs1,
  input  logic [RAW-1:0]  in_rs2,
  output logic [RAW-1:0]  rs1_addr,
  output logic [RAW-1:0]  rs2_addr,
  input  logic            rs1_busy,
  input  logic            rs2_busy,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            redir_valid,
  input  logic            redir_ready,
  output logic [XLEN-1:0] redir_pc,
  output logic            done,
  output logic            done_taken
);

  state_e          state;
  op_e             op_q;
  logic [2:0]      funct_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] imm_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;

  logic            operand_wait;
  logic            cmp_taken;
  logic            taken;
  logic            need_redir;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] jalr_target;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] redir_target;

  // kill gates both handshakes combinationally so a flush can never let an
  // op in or complete a redirect in the same cycle.
  assign in_ready    = (state == ST_IDLE) && !kill;
  assign redir_valid = (state == ST_REDIR) && !kill;

  // Only the operands the op actually reads hold it in OPER.
  always_comb begin
    operand_wait = 1'b0;
    case (op_q)
      OP_BR:   operand_wait = rs1_busy | rs2_busy;
      OP_JALR: operand_wait = rs1_busy;
      default: operand_wait = 1'b0;
    endcase
  end

  ysyx_23060203_br_cmp #(.XLEN(XLEN)) u_cmp (
    .a     (a_q),
    .b     (b_q),
    .funct (funct_q),
    .taken (cmp_taken)
  );

  assign taken       = (op_q == OP_BR) ? cmp_taken : 1'b1;
  assign br_target   = pc_q + imm_q;
  assign jalr_target = (a_q + imm_q) & {{(XLEN-1){1'b1}}, 1'b0};
  assign target      = (op_q == OP_JALR) ? jalr_target : br_target;

`ifdef YSYX_23060203_BTFN_EN
  logic            pred_q;
  logic [XLEN-1:0] fallthrough;

  // The IFU already follows its prediction, so only a wrong guess needs a
  // redirect, and the correction may point back to the fall-through path.
  assign fallthrough  = pc_q + XLEN'(4);
  assign need_redir   = (op_q == OP_JALR) || (taken != pred_q);
  assign redir_target = taken ? target : fallthrough;

  // Static prediction made by the IFU, captured with the op.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pred_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      pred_q <= (decode_op(in_op) == OP_BR) ? in_imm[XLEN-1] : 1'b1;
    end
  end
`else
  // Without speculation the IFU always falls through, so every taken op redirects.
  assign need_redir   = taken;
  assign redir_target = target;
`endif

  // Resolver FSM plus its op/operand registers: IDLE latches the op, OPER
  // waits for and captures operands, EVAL decides, REDIR holds the request
  // until the IFU takes it. done is a single-cycle pulse on retirement.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      op_q       <= OP_BR;
      funct_q    <= '0;
      pc_q       <= '0;
      imm_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rs1_addr   <= '0;
      rs2_addr   <= '0;
      redir_pc   <= '0;
      done       <= 1'b0;
      done_taken <= 1'b0;
    end else begin
      done <= 1'b0;
      if (kill) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (in_valid) begin
              op_q     <= decode_op(in_op);
              funct_q  <= in_funct;
              pc_q     <= in_pc;
              imm_q    <= in_imm;
              rs1_addr <= in_rs1;
              rs2_addr <= in_rs2;
              state    <= ST_OPER;
            end
          end
          ST_OPER: begin
            if (!operand_wait) begin
              a_q   <= rs1_data;
              b_q   <= rs2_data;
              state <= ST_EVAL;
            end
          end
          ST_EVAL: begin
            done_taken <= taken;
            if (need_redir) begin
              redir_pc <= redir_target;
              state    <= ST_REDIR;
            end else begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end
          end
          ST_REDIR: begin
            if (redir_ready) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060203_branch_ctl.sv
// tb_ysyx_23060203_branch_ctl
//   Directed scenarios followed by randomized ops for ysyx_23060203_branch_ctl.
//   Expected outcomes come from a behavioural model of the control-transfer
//   rules (native signed/unsigned compares, plain address arithmetic).
//   Honors YSYX_23060203_BTFN_EN the same way the design does.
module tb_ysyx_23060203_branch_ctl;

  logic        clock;
  logic        reset_n;
  logic        kill;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [2:0]  in_funct;
  logic [31:0] in_pc;
  logic [31:0] in_imm;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_busy;
  logic        rs2_busy;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        redir_valid;
  logic        redir_ready;
  logic [31:0] redir_pc;
  logic        done;
  logic        done_taken;

  int checks   = 0;
  int failures = 0;

  ysyx_23060203_branch_ctl #(.XLEN(32), .RAW(5)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .kill        (kill),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_funct    (in_funct),
    .in_pc       (in_pc),
    .in_imm      (in_imm),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .redir_valid (redir_valid),
    .redir_ready (redir_ready),
    .redir_pc    (redir_pc),
    .done        (done),
    .done_taken  (done_taken)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      $error("[TB] %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Architectural outcome of one control-transfer op.
  function automatic void model(input logic [1:0] op, input logic [2:0] f,
                                input logic [31:0] pc, input logic [31:0] imm,
                                input logic [31:0] a, input logic [31:0] b,
                                output bit tk, output bit rd, output logic [31:0] rpc);
    int          kind;
    logic [31:0] tgt;
    logic [31:0] fall;
    bit          pred;
    kind = (op == 2'd3) ? 1 : int'(op);
    fall = pc + 32'd4;
    tk   = 1'b1;
    tgt  = pc + imm;
    if (kind == 0) begin
      case (f)
        3'd0:    tk = (a == b);
        3'd1:    tk = (a != b);
        3'd4:    tk = ($signed(a) <  $signed(b));
        3'd5:    tk = ($signed(a) >= $signed(b));
        3'd6:    tk = (a <  b);
        3'd7:    tk = (a >= b);
        default: tk = 1'b0;
      endcase
    end else if (kind == 2) begin
      tgt = (a + imm) & 32'hFFFF_FFFE;
    end
`ifdef YSYX_23060203_BTFN_EN
    pred = (kind == 0) ? imm[31] : 1'b1;
    rd   = (kind == 2) || (tk != pred);
    rpc  = tk ? tgt : fall;
`else
    pred = 1'b0;
    rd   = tk;
    rpc  = tgt;
`endif
  endfunction

  // Runs one op end to end, from offer at the current cycle to one cycle
  // after done, checking handshake timing and results along the way.
  // nb: cycles the needed operands stay busy; rdly: cycles the IFU stalls;
  // noise: busy level on operands the op does not read.
  task automatic applyStimulus(input logic [1:0] op, input logic [2:0] f,
                               input logic [31:0] pc, input logic [31:0] imm,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] r1, input logic [4:0] r2,
                               input int nb, input int rdly, input bit noise);
    bit          tk;
    bit          rd;
    logic [31:0] rpc;
    bit          need1;
    bit          need2;
    int          wait_n;
    model(op, f, pc, imm, a, b, tk, rd, rpc);
    need1  = (op == 2'd0) || (op == 2'd2);
    need2  = (op == 2'd0);
    wait_n = need1 ? nb : 0;

    in_valid    = 1'b1;
    in_op       = op;
    in_funct    = f;
    in_pc       = pc;
    in_imm      = imm;
    in_rs1      = r1;
    in_rs2      = r2;
    rs1_data    = a;
    rs2_data    = b;
    rs1_busy    = need1 ? (nb > 0) : noise;
    rs2_busy    = need2 ? (nb > 0) : noise;
    redir_ready = (rdly == 0);
    #1;
    checkOutput("accept_ready", {31'd0, in_ready}, 32'd1);

    @(posedge clock); #1;
    in_valid = 1'b0;
    in_pc    = $urandom;
    in_imm   = $urandom;
    in_rs1   = 5'($urandom);
    in_rs2   = 5'($urandom);
    checkOutput("rs1_addr", {27'd0, rs1_addr}, {27'd0, r1});
    checkOutput("rs2_addr", {27'd0, rs2_addr}, {27'd0, r2});

    for (int i = 0; i < wait_n; i++) begin
      checkOutput("oper_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("oper_redir", {31'd0, redir_valid}, 32'd0);
      checkOutput("oper_done", {31'd0, done}, 32'd0);
      @(posedge clock); #1;
    end
    rs1_busy = need1 ? 1'b0 : noise;
    rs2_busy = need2 ? 1'b0 : noise;

    @(posedge clock); #1;
    // Operands must already be captured; scramble the RF outputs.
    rs1_data = ~a;
    rs2_data = b ^ 32'h5A5A_5A5A;
    checkOutput("eval_done", {31'd0, done}, 32'd0);
    checkOutput("eval_redir", {31'd0, redir_valid}, 32'd0);

    @(posedge clock); #1;
    checkOutput("result_redir", {31'd0, redir_valid}, {31'd0, rd});
    checkOutput("result_done", {31'd0, done}, {31'd0, !rd});
    if (rd) begin
      checkOutput("redir_pc", redir_pc, rpc);
      if (rdly > 0) begin
        for (int j = 1; j < rdly; j++) begin
          @(posedge clock); #1;
          checkOutput("stall_valid", {31'd0, redir_valid}, 32'd1);
          checkOutput("stall_pc", redir_pc, rpc);
          checkOutput("stall_done", {31'd0, done}, 32'd0);
        end
        redir_ready = 1'b1;
      end
      @(posedge clock); #1;
      checkOutput("hs_done", {31'd0, done}, 32'd1);
      checkOutput("hs_valid", {31'd0, redir_valid}, 32'd0);
    end
    checkOutput("done_taken", {31'd0, done_taken}, {31'd0, tk});
    checkOutput("done_ready", {31'd0, in_ready}, 32'd1);

    redir_ready = 1'b0;
    rs1_busy    = 1'b0;
    rs2_busy    = 1'b0;
    @(posedge clock); #1;
    checkOutput("done_pulse", {31'd0, done}, 32'd0);
  endtask

  // Accepts an op with free operands and stops in its first REDIR cycle.
  task automatic startOp(input logic [1:0] op, input logic [2:0] f,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] a, input logic [31:0] b);
    in_valid    = 1'b1;
    in_op       = op;
    in_funct    = f;
    in_pc       = pc;
    in_imm      = imm;
    in_rs1      = 5'd7;
    in_rs2      = 5'd9;
    rs1_data    = a;
    rs2_data    = b;
    rs1_busy    = 1'b0;
    rs2_busy    = 1'b0;
    redir_ready = 1'b0;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
  endtask

  function automatic logic [31:0] pickData();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    reset_n     = 1'b0;
    kill        = 1'b0;
    in_valid    = 1'b0;
    in_op       = 2'd0;
    in_funct    = 3'd0;
    in_pc       = 32'd0;
    in_imm      = 32'd0;
    in_rs1      = 5'd0;
    in_rs2      = 5'd0;
    rs1_busy    = 1'b0;
    rs2_busy    = 1'b0;
    rs1_data    = 32'd0;
    rs2_data    = 32'd0;
    redir_ready = 1'b0;

    #12;
    checkOutput("rst_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_redir_valid", {31'd0, redir_valid}, 32'd0);
    checkOutput("rst_redir_pc", redir_pc, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_done_taken", {31'd0, done_taken}, 32'd0);
    checkOutput("rst_rs1_addr", {27'd0, rs1_addr}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;

    $display("[TB] directed: BEQ taken");
    applyStimulus(2'd0, 3'b000, 32'h8000_0000, 32'h10, 32'd5, 32'd5, 5'd1, 5'd2, 0, 0, 1'b0);
    checkOutput("beq_pc_const", redir_pc, 32'h8000_0010);

    $display("[TB] directed: BLTU / BLT");
    applyStimulus(2'd0, 3'b110, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'd1, 5'd3, 5'd4, 0, 0, 1'b0);
    checkOutput("bltu_not_taken", {31'd0, done_taken}, 32'd0);
    applyStimulus(2'd0, 3'b100, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'd1, 5'd3, 5'd4, 0, 0, 1'b0);
    checkOutput("blt_taken", {31'd0, done_taken}, 32'd1);

    $display("[TB] directed: JALR with busy rs1");
    applyStimulus(2'd2, 3'b000, 32'h400, 32'd2, 32'h1001, 32'd0, 5'd6, 5'd8, 4, 0, 1'b1);
    checkOutput("jalr_pc_const", redir_pc, 32'h1002);

    $display("[TB] directed: kill during redirect stall");
    startOp(2'd0, 3'b001, 32'h2000, 32'h40, 32'd1, 32'd2);
    checkOutput("kill_valid_1", {31'd0, redir_valid}, 32'd1);
    checkOutput("kill_pc_1", redir_pc, 32'h2040);
    @(posedge clock); #1;
    checkOutput("kill_valid_2", {31'd0, redir_valid}, 32'd1);
    kill = 1'b1;
    #1;
    checkOutput("kill_drop", {31'd0, redir_valid}, 32'd0);
    checkOutput("kill_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clock); #1;
    kill = 1'b0;
    #1;
    checkOutput("kill_idle", {31'd0, in_ready}, 32'd1);
    checkOutput("kill_no_done", {31'd0, done}, 32'd0);
    checkOutput("kill_no_redir", {31'd0, redir_valid}, 32'd0);
    @(posedge clock); #1;
    checkOutput("kill_no_done_2", {31'd0, done}, 32'd0);

`ifdef YSYX_23060203_BTFN_EN
    $display("[TB] directed: backward BGE");
    applyStimulus(2'd0, 3'b101, 32'h100, 32'hFFFF_FFF8, 32'd1, 32'd2, 5'd1, 5'd2, 0, 1, 1'b0);
    checkOutput("btfn_fall_pc", redir_pc, 32'h104);
    applyStimulus(2'd0, 3'b101, 32'h100, 32'hFFFF_FFF8, 32'd2, 32'd1, 5'd1, 5'd2, 0, 0, 1'b0);
    checkOutput("btfn_taken_done", {31'd0, done_taken}, 32'd1);
`endif

    $display("[TB] directed: reset during redirect");
    startOp(2'd2, 3'b000, 32'h300, 32'd4, 32'h500, 32'd0);
    checkOutput("rr_valid", {31'd0, redir_valid}, 32'd1);
    checkOutput("rr_pc", redir_pc, 32'h504);
    reset_n = 1'b0;
    #1;
    checkOutput("rr_async_valid", {31'd0, redir_valid}, 32'd0);
    checkOutput("rr_async_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rr_async_pc", redir_pc, 32'd0);
    checkOutput("rr_async_addr", {27'd0, rs1_addr}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;

    $display("[TB] directed: kill with in_valid in IDLE");
    kill     = 1'b1;
    in_valid = 1'b1;
    in_op    = 2'd1;
    in_rs1   = 5'd17;
    #1;
    checkOutput("ki_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clock); #1;
    kill     = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("ki_still_idle", {31'd0, in_ready}, 32'd1);
    checkOutput("ki_addr", {27'd0, rs1_addr}, 32'd0);

    $display("[TB] randomized ops");
    for (int n = 0; n < 60; n++) begin
      a = pickData();
      b = ($urandom_range(0, 3) == 0) ? a : pickData();
      applyStimulus(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                    $urandom, pickData(), a, b,
                    5'($urandom), 5'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
